sha3_squeeze: RTL

Output/squeeze stage of the SHA3 core; the reader side of the permutation's 1600-bit state bus. It captures the permuted state when the round engine signals completion and streams the rate portion out as 64-bit digest words over a valid/ready interface. For SHAKE modes it requests further permutations when more output is needed than one rate block holds.

---
 rtl/sha3_squeeze.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sha3_squeeze.sv
// SHA3 squeeze stage: captures the permuted state and streams rate lanes as
// 64-bit digest words, requesting extra permutations for long SHAKE outputs.
module sha3_squeeze #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [LEN_W-1:0] out_len,
  input  logic             state_valid,
  input  logic [1599:0]    state_in,
  output logic             perm_req,
  output logic [63:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic [7:0]       dout_keep,
  output logic             busy,
  output logic             done
);

  localparam int LANE_W    = 64;
  localparam int MAX_LANES = 21;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ST,
    STREAM,
    REQ,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [2:0]        mode_r;
  logic [LEN_W-1:0]  n_r;
  logic [4:0]        rate_r;
  logic [4:0]        lane_idx;
  logic [LEN_W-1:0]  word_cnt;
  logic [LANE_W-1:0] lanes [MAX_LANES];

  logic              legal;
  logic [LEN_W-1:0]  n_sel;
  logic [4:0]        rate_sel;
  logic              fire;
  logic              last_word;
  logic              block_end;
  logic              unused_capacity;

  // Capacity lanes never leave the core.
  assign unused_capacity = ^state_in[1599:MAX_LANES*LANE_W];

  always_comb begin
    n_sel    = out_len;
    rate_sel = 5'd17;
    unique case (mode)
      3'd0:    begin n_sel = LEN_W'(4); rate_sel = 5'd18; end
      3'd1:    begin n_sel = LEN_W'(4); rate_sel = 5'd17; end
      3'd2:    begin n_sel = LEN_W'(6); rate_sel = 5'd13; end
      3'd3:    begin n_sel = LEN_W'(8); rate_sel = 5'd9;  end
      3'd4:    rate_sel = 5'd21;
      default: rate_sel = 5'd17;
    endcase
  end

  assign legal     = (mode <= 3'd5) && ((mode < 3'd4) || (out_len != '0));
  assign fire      = dout_valid && dout_ready;
  assign last_word = (word_cnt == n_r - LEN_W'(1));
  assign block_end = (lane_idx == rate_r - 5'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    dout_valid = 1'b0;
    perm_req   = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && legal) state_next = WAIT_ST;
      end
      WAIT_ST: if (state_valid) state_next = STREAM;
      STREAM: begin
        dout_valid = 1'b1;
        if (fire) begin
          if (last_word)      state_next = DONE;
          else if (block_end) state_next = REQ;
        end
      end
      REQ: begin
        perm_req   = 1'b1;
        state_next = WAIT_ST;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word outputs are gated by dout_valid so they read zero whenever idle.
  always_comb begin
    dout      = '0;
    dout_last = 1'b0;
    dout_keep = '0;
    if (dout_valid) begin
      dout      = lanes[lane_idx];
      dout_last = last_word;
      dout_keep = (last_word && mode_r == 3'd0) ? 8'h0F : 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r   <= '0;
      n_r      <= '0;
      rate_r   <= '0;
      lane_idx <= '0;
      word_cnt <= '0;
      for (int unsigned i = 0; i < MAX_LANES; i++) lanes[i] <= '0;
    end else begin
      if (state == IDLE && start && legal) begin
        mode_r   <= mode;
        n_r      <= n_sel;
        rate_r   <= rate_sel;
        word_cnt <= '0;
      end
      if (state == WAIT_ST && state_valid) begin
        lane_idx <= '0;
        for (int unsigned i = 0; i < MAX_LANES; i++)
          lanes[i] <= state_in[LANE_W*i +: LANE_W];
      end
      if (state == STREAM && fire) begin
        word_cnt <= word_cnt + LEN_W'(1);
        lane_idx <= lane_idx + 5'd1;
      end
    end
  end

endmodule
